sensor_conditioner: RTL

- Upstream front end of mainproj. Converts four raw, asynchronous patient sensors (tilt, blink, sip/puff, head switch) into a clean one-hot command word.
- Output drives mainproj's sw[3:0] input.
- Functions: synchronisation, per-channel debounce, a dwell-time check for intentional gestures, multi-sensor conflict rejection and a post-release lockout. Together these stop tremor and spasms from issuing commands.

---
 rtl/sensor_conditioner.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sensor_conditioner.sv
// Sensor front end: turns four raw, asynchronous patient sensors into a clean
// one-hot command level. It synchronises, debounces, checks dwell time, rejects conflicts and enforces a lockout.
module sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DWELL_CYCLES    = 8,
  parameter int LOCKOUT_CYCLES  = 8,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sensor_raw,
  output logic [3:0] sw_out,
  output logic       cmd_valid,
  output logic       conflict,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DWELL   = 2'd1;
  localparam logic [1:0] ACTIVE  = 2'd2;
  localparam logic [1:0] LOCKOUT = 2'd3;

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCKOUT_CYCLES - 1);

  logic [3:0]       sync1, sync2;
  logic [3:0]       db;
  logic [CNT_W-1:0] db_cnt [4];
  logic [1:0]       state;
  logic [3:0]       cap;
  logic [CNT_W-1:0] dwell_cnt;
  logic [CNT_W-1:0] lock_cnt;
  logic             multi;
  logic             one_hot;

  // Two-flop synchroniser for the asynchronous sensor levels.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sensor_raw;
      sync2 <= sync1;
    end
  end

  // Per-channel debounce: a channel flips only after DEBOUNCE_CYCLES disagreeing samples in a row.
  // NOTE: the counter array is small and must start from zero, so it is reset element by element.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db[i]     <= ~db[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // x & (x-1) clears the lowest set bit; a non-zero result means two or more channels are active.
  always_comb begin
    multi   = (db & (db - 4'd1)) != 4'd0;
    one_hot = (db != 4'd0) && !multi;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cap       <= '0;
      dwell_cnt <= '0;
      lock_cnt  <= '0;
      sw_out    <= '0;
      cmd_valid <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      conflict  <= ((state == IDLE) || (state == DWELL)) && multi;
      case (state)
        IDLE: begin
          if (one_hot) begin
            state     <= DWELL;
            cap       <= db;
            dwell_cnt <= '0;
          end
        end
        DWELL: begin
          if (db != cap) begin
            state <= IDLE;
          end else if (dwell_cnt == DWELL_LAST) begin
            state     <= ACTIVE;
            sw_out    <= cap;
            cmd_valid <= 1'b1;
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        ACTIVE: begin
          if (db != cap) begin
            state    <= LOCKOUT;
            sw_out   <= '0;
            lock_cnt <= '0;
          end
        end
        default: begin
          // Lockout counter saturates, so a held input simply parks here until every channel releases.
          if (lock_cnt >= LOCK_LAST) begin
            if (db == 4'd0) state <= IDLE;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule
